// File: rtl/irq_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode interrupt/trap controller.
// Latency: none (constants, types and a pure helper function only).
// Backpressure: none.
package irq_trap_ctrl_pkg;

    // Default data/PC width; RV32 builds override the XLEN parameter with 32.
    localparam int IRQ_XLEN_DEFAULT = 64;

    // Width of the exception-code field written into the low bits of mcause.
    localparam int IRQ_CODE_W = 4;

    // mcause exception codes for machine-level interrupts.
    localparam logic [IRQ_CODE_W-1:0] IRQ_CAUSE_MEI = 4'd11;
    localparam logic [IRQ_CODE_W-1:0] IRQ_CAUSE_MSI = 4'd3;
    localparam logic [IRQ_CODE_W-1:0] IRQ_CAUSE_MTI = 4'd7;

    // Interrupt lines from the CLINT/PLIC are active-high levels.
    localparam logic IRQ_LVL_ACTIVE = 1'b1;

    // Trap sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HANDLER = 2'd2
    } irq_state_t;

    // A source participates in arbitration when it is pending and enabled.
    function automatic logic irq_hit(input logic pend, input logic en);
        return (pend == IRQ_LVL_ACTIVE) && en;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Reset-to-zero flop chain bringing an asynchronous level into the clk domain.
// Latency: STAGES clk cycles from d to q.
// Backpressure: none; the level is sampled every cycle.
module irq_sync #(
    parameter int STAGES = 2  // at least 2 for metastability protection
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous level through the synchronizer chain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt controller: mip tracking, enable gating, trap request/handler tracking.
// Latency: mip_mtip 1 cycle, mip_meip EXT_SYNC_STAGES cycles; trap_req rises the edge after a retire with take.
// Backpressure: trap_req/cause/epc are held until trap_ack; no new trap until mret retires.
// Optional: define IRQ_TRAP_CTRL_MSIP_EN to add the software interrupt (msip, mie_msie, mip_msip).
module irq_trap_ctrl
    import irq_trap_ctrl_pkg::*;
#(
    parameter int XLEN            = IRQ_XLEN_DEFAULT,
    parameter int EXT_SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            mtime_interrupt,
    input  logic            meip_async,
    input  logic            mstatus_mie,
    input  logic            mie_mtie,
    input  logic            mie_meie,
`ifdef IRQ_TRAP_CTRL_MSIP_EN
    input  logic            msip,
    input  logic            mie_msie,
    output logic            mip_msip,
`endif
    input  logic            retire_valid,
    input  logic [XLEN-1:0] retire_next_pc,
    input  logic            is_mret_instr,
    input  logic            trap_ack,
    output logic            trap_req,
    output logic [XLEN-1:0] trap_cause,
    output logic [XLEN-1:0] trap_epc,
    output logic            mip_mtip,
    output logic            mip_meip,
    output logic            in_handler
);

    irq_state_t state_q;
    irq_state_t state_d;

    logic                  meip_sync;
    logic                  mei_hit;
    logic                  mti_hit;
    logic                  any_hit;
    logic                  take;
    logic                  capture;
    logic [IRQ_CODE_W-1:0] cause_code;
    logic [XLEN-1:0]       cause_full;

    // External interrupt arrives asynchronously and must be synchronized first.
    irq_sync #(
        .STAGES (EXT_SYNC_STAGES)
    ) u_meip_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (meip_async),
        .q    (meip_sync)
    );

    assign mip_meip = meip_sync;

    // Timer level is already in the clk domain; one register stage for mip.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mip_mtip <= 1'b0;
        end else begin
            mip_mtip <= (mtime_interrupt == IRQ_LVL_ACTIVE);
        end
    end

`ifdef IRQ_TRAP_CTRL_MSIP_EN
    logic msi_hit;

    // Software interrupt level is synchronous; one register stage for mip.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mip_msip <= 1'b0;
        end else begin
            mip_msip <= (msip == IRQ_LVL_ACTIVE);
        end
    end

    assign msi_hit = irq_hit(mip_msip, mie_msie);
    assign any_hit = mei_hit | msi_hit | mti_hit;
`else
    assign any_hit = mei_hit | mti_hit;
`endif

    assign mei_hit = irq_hit(mip_meip, mie_meie);
    assign mti_hit = irq_hit(mip_mtip, mie_mtie);
    assign take    = mstatus_mie & ~in_handler & any_hit;

    // Fixed-priority cause selection: external first, timer last.
    always_comb begin
        cause_code = IRQ_CAUSE_MTI;
        if (mei_hit) begin
            cause_code = IRQ_CAUSE_MEI;
        end
`ifdef IRQ_TRAP_CTRL_MSIP_EN
        else if (msi_hit) begin
            cause_code = IRQ_CAUSE_MSI;
        end
`endif
        else begin
            cause_code = IRQ_CAUSE_MTI;
        end
    end

    // Build mcause: interrupt flag in the MSB, exception code in the low bits.
    always_comb begin
        cause_full                   = '0;
        cause_full[XLEN-1]           = 1'b1;
        cause_full[IRQ_CODE_W-1:0]   = cause_code;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: traps only start at a retire boundary; ack and mret only matter in their own state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take && retire_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (trap_ack) begin
                    state_d = ST_HANDLER;
                end
            end
            ST_HANDLER: begin
                if (retire_valid && is_mret_instr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state, so they drop immediately on async reset.
    always_comb begin
        trap_req   = (state_q == ST_REQ);
        in_handler = (state_q == ST_HANDLER);
        capture    = (state_q == ST_IDLE) && take && retire_valid;
    end

    // Cause and return PC are latched once at the committing retire and held through REQ.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trap_cause <= '0;
            trap_epc   <= '0;
        end else if (capture) begin
            trap_cause <= cause_full;
            trap_epc   <= retire_next_pc;
        end
    end

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Self-checking bench for irq_trap_ctrl: directed scenarios followed by a randomized run.
// Latency: outputs compared 1 time unit after every rising clock edge.
// Backpressure: trap_ack driven by the bench.
module tb_irq_trap_ctrl;

    localparam int XLEN = 64;
    localparam int SYNC = 2;
    localparam logic [63:0] CAUSE_MEI = 64'h8000_0000_0000_000B;
    localparam logic [63:0] CAUSE_MTI = 64'h8000_0000_0000_0007;

    logic            clk = 1'b0;
    logic            rstn;
    logic            mtime_interrupt;
    logic            meip_async;
    logic            mstatus_mie;
    logic            mie_mtie;
    logic            mie_meie;
    logic            retire_valid;
    logic [XLEN-1:0] retire_next_pc;
    logic            is_mret_instr;
    logic            trap_ack;
    logic            trap_req;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_epc;
    logic            mip_mtip;
    logic            mip_meip;
    logic            in_handler;

    int checks   = 0;
    int failures = 0;

    // Reference model: committed request flag, handler flag, latched cause/epc, input histories.
    bit          m_req;
    bit          m_hand;
    logic [63:0] m_epc;
    logic [63:0] m_cause;
    bit          m_mtip;
    bit          m_hist [SYNC];

    logic [63:0] saved_cause;
    logic [63:0] saved_epc;

    always #5 clk = ~clk;

    irq_trap_ctrl #(
        .XLEN            (XLEN),
        .EXT_SYNC_STAGES (SYNC)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .mtime_interrupt (mtime_interrupt),
        .meip_async      (meip_async),
        .mstatus_mie     (mstatus_mie),
        .mie_mtie        (mie_mtie),
        .mie_meie        (mie_meie),
        .retire_valid    (retire_valid),
        .retire_next_pc  (retire_next_pc),
        .is_mret_instr   (is_mret_instr),
        .trap_ack        (trap_ack),
        .trap_req        (trap_req),
        .trap_cause      (trap_cause),
        .trap_epc        (trap_epc),
        .mip_mtip        (mip_mtip),
        .mip_meip        (mip_meip),
        .in_handler      (in_handler)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req   = 1'b0;
        m_hand  = 1'b0;
        m_epc   = '0;
        m_cause = '0;
        m_mtip  = 1'b0;
        for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".trap_req"},   64'(trap_req),   64'(m_req));
        chk({tag, ".in_handler"}, 64'(in_handler), 64'(m_hand));
        chk({tag, ".mip_mtip"},   64'(mip_mtip),   64'(m_mtip));
        chk({tag, ".mip_meip"},   64'(mip_meip),   64'(m_hist[SYNC-1]));
        chk({tag, ".trap_cause"}, trap_cause,      m_cause);
        chk({tag, ".trap_epc"},   trap_epc,        m_epc);
    endtask

    // Advance one clock: predict from the rules using pre-edge inputs, then compare after the edge.
    task automatic step(input string tag);
        bit ext_ok;
        bit tmr_ok;
        ext_ok = m_hist[SYNC-1] && mie_meie;
        tmr_ok = m_mtip && mie_mtie;
        if (!m_req && !m_hand) begin
            if (mstatus_mie && (ext_ok || tmr_ok) && retire_valid) begin
                m_req   = 1'b1;
                m_epc   = retire_next_pc;
                m_cause = ext_ok ? CAUSE_MEI : CAUSE_MTI;
            end
        end else if (m_req) begin
            if (trap_ack) begin
                m_req  = 1'b0;
                m_hand = 1'b1;
            end
        end else if (retire_valid && is_mret_instr) begin
            m_hand = 1'b0;
        end
        for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = meip_async;
        m_mtip    = mtime_interrupt;
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic retire_once(input logic [63:0] pc, input logic mret, input string tag);
        retire_valid   = 1'b1;
        retire_next_pc = pc;
        is_mret_instr  = mret;
        step(tag);
        retire_valid   = 1'b0;
        is_mret_instr  = 1'b0;
    endtask

    task automatic ack_once(input string tag);
        trap_ack = 1'b1;
        step(tag);
        trap_ack = 1'b0;
    endtask

    initial begin
        rstn            = 1'b0;
        mtime_interrupt = 1'b0;
        meip_async      = 1'b0;
        mstatus_mie     = 1'b0;
        mie_mtie        = 1'b0;
        mie_meie        = 1'b0;
        retire_valid    = 1'b0;
        retire_next_pc  = '0;
        is_mret_instr   = 1'b0;
        trap_ack        = 1'b0;
        model_reset();

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        rstn = 1'b1;

        // Timer trap at a retire boundary, held 5 cycles, then acknowledged.
        mstatus_mie     = 1'b1;
        mie_mtie        = 1'b1;
        mtime_interrupt = 1'b1;
        step("tmr_pend");
        chk("tmr_mip_latency", 64'(mip_mtip), 64'd1);
        retire_once(64'h8000_0010, 1'b0, "tmr_retire");
        chk("tmr_req",   64'(trap_req), 64'd1);
        chk("tmr_cause", trap_cause, 64'h8000_0000_0000_0007);
        chk("tmr_epc",   trap_epc,   64'h0000_0000_8000_0010);
        for (int i = 0; i < 5; i++) step("tmr_hold");
        chk("tmr_held", 64'(trap_req), 64'd1);
        ack_once("tmr_ack");
        chk("tmr_in_handler", 64'(in_handler), 64'd1);
        chk("tmr_req_drop",   64'(trap_req),   64'd0);
        mtime_interrupt = 1'b0;
        retire_once(64'h100, 1'b1, "tmr_mret");
        chk("tmr_mret_exit", 64'(in_handler), 64'd0);

        // Simultaneous external and timer: external wins, timer follows after mret.
        mie_meie        = 1'b1;
        meip_async      = 1'b1;
        mtime_interrupt = 1'b1;
        repeat (3) step("both_pend");
        retire_once(64'h200, 1'b0, "both_retire");
        chk("both_cause_mei", trap_cause, CAUSE_MEI);
        ack_once("both_ack");
        meip_async = 1'b0;
        repeat (3) step("both_in_handler");
        retire_once(64'h300, 1'b1, "both_mret");
        chk("both_no_req_at_mret", 64'(trap_req), 64'd0);
        retire_once(64'h400, 1'b0, "both_next");
        chk("both_cause_mti", trap_cause, CAUSE_MTI);
        chk("both_req_mti",   64'(trap_req), 64'd1);
        ack_once("both_ack2");
        retire_once(64'h500, 1'b1, "both_mret2");

        // Gating by mstatus.MIE across 20 retires.
        mstatus_mie = 1'b0;
        for (int i = 0; i < 20; i++) begin
            retire_once(64'h1000 + 64'(i * 4), 1'b0, "gate_off");
            chk("gate_off_req", 64'(trap_req), 64'd0);
        end
        mstatus_mie = 1'b1;
        step("gate_on_no_retire");
        chk("gate_on_wait_retire", 64'(trap_req), 64'd0);
        retire_once(64'h2000, 1'b0, "gate_on_retire");
        chk("gate_on_req", 64'(trap_req), 64'd1);

        // Commitment: dropping the level in REQ leaves request, cause and epc intact.
        saved_cause     = trap_cause;
        saved_epc       = trap_epc;
        mtime_interrupt = 1'b0;
        mie_mtie        = 1'b0;
        for (int i = 0; i < 4; i++) begin
            retire_once(64'h3000, 1'b1, "commit_hold");
            chk("commit_req",   64'(trap_req), 64'd1);
            chk("commit_cause", trap_cause, saved_cause);
            chk("commit_epc",   trap_epc,   saved_epc);
        end
        ack_once("commit_ack");

        // Handler masking of a new external interrupt; synchronizer latency.
        meip_async = 1'b1;
        step("meip_sync1");
        chk("meip_latency1", 64'(mip_meip), 64'd0);
        step("meip_sync2");
        chk("meip_latency2", 64'(mip_meip), 64'd1);
        for (int i = 0; i < 4; i++) begin
            retire_once(64'h4000, 1'b0, "mask_retire");
            chk("mask_no_req", 64'(trap_req), 64'd0);
        end
        retire_once(64'h4100, 1'b1, "mask_mret");
        chk("mask_exit", 64'(in_handler), 64'd0);
        chk("mask_no_req_at_mret", 64'(trap_req), 64'd0);
        retire_once(64'h4200, 1'b0, "mask_take");
        chk("mask_req",   64'(trap_req), 64'd1);
        chk("mask_cause", trap_cause, CAUSE_MEI);

        // Asynchronous reset while in REQ.
        mtime_interrupt = 1'b1;
        mie_mtie        = 1'b1;
        step("pre_reset");
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        chk("arst_req",      64'(trap_req),   64'd0);
        chk("arst_handler",  64'(in_handler), 64'd0);
        chk("arst_mip_mtip", 64'(mip_mtip),   64'd0);
        chk("arst_mip_meip", 64'(mip_meip),   64'd0);
        @(negedge clk);
        rstn = 1'b1;
        step("post_reset_pend");
        retire_once(64'h5000, 1'b0, "post_reset_take");
        chk("post_reset_req", 64'(trap_req), 64'd1);
        ack_once("post_reset_ack");
        retire_once(64'h5100, 1'b1, "post_reset_mret");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) mtime_interrupt = ~mtime_interrupt;
            if ($urandom_range(0, 7) == 0) meip_async      = ~meip_async;
            mstatus_mie    = ($urandom_range(0, 3) != 0);
            mie_mtie       = ($urandom_range(0, 3) != 0);
            mie_meie       = ($urandom_range(0, 3) != 0);
            retire_valid   = ($urandom_range(0, 1) == 1);
            retire_next_pc = {32'($urandom), 32'($urandom)};
            is_mret_instr  = ($urandom_range(0, 3) == 0);
            trap_ack       = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
